// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit: program counter and IF/ID buffer with stall, branch redirect
// and HALT handling.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] PC_STEP   = WIDTH'(2),
  parameter logic [3:0]       HALT_OP   = 4'hF,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] if_instruction,
  output logic [WIDTH-1:0] if_from_pc,
  output logic [WIDTH-1:0] id_instruction,
  output logic [WIDTH-1:0] id_pc_plus2,
  output logic             id_valid,
  output logic             halted
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_id_instr, w_id_instr_nxt;
  logic [WIDTH-1:0] r_id_pc2, w_id_pc2_nxt;
  logic             r_id_valid, w_id_valid_nxt;

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_target;
  logic             w_is_halt;

  assign w_pc_inc  = r_pc + PC_STEP;
  // Instructions are halfword aligned, so the target LSB is dropped.
  assign w_target  = branch_target & ~WIDTH'(1);
  assign w_is_halt = (if_instruction[WIDTH-1:WIDTH-4] == HALT_OP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_id_instr <= NOP_INSTR;
      r_id_pc2   <= '0;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc2   <= w_id_pc2_nxt;
      r_id_valid <= w_id_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_instr_nxt = r_id_instr;
    w_id_pc2_nxt   = r_id_pc2;
    w_id_valid_nxt = r_id_valid;

    if (branch_taken) begin
      // A resolving branch also cancels a HALT fetched on the wrong path.
      w_state_nxt    = S_RUN;
      w_pc_nxt       = w_target;
      w_id_instr_nxt = NOP_INSTR;
      w_id_pc2_nxt   = '0;
      w_id_valid_nxt = 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          w_id_instr_nxt = if_instruction;
          w_id_pc2_nxt   = w_pc_inc;
          w_id_valid_nxt = 1'b1;
          if (w_is_halt) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        S_HALT: begin
          w_id_instr_nxt = NOP_INSTR;
          w_id_pc2_nxt   = '0;
          w_id_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  assign if_from_pc     = r_pc;
  assign id_instruction = r_id_instr;
  assign id_pc_plus2    = r_id_pc2;
  assign id_valid       = r_id_valid;
  assign halted         = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit: directed stimulus with a behavioural fetch model and literal
// expectations.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] if_instruction;
  logic [15:0] if_from_pc;
  logic [15:0] id_instruction;
  logic [15:0] id_pc_plus2;
  logic        id_valid;
  logic        halted;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_instruction(if_instruction),
    .if_from_pc    (if_from_pc),
    .id_instruction(id_instruction),
    .id_pc_plus2   (id_pc_plus2),
    .id_valid      (id_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: a HALT word at 0x0010, otherwise 0x1000 + address.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hF000 : 16'h1000 + a;
  endfunction

  assign if_instruction = mem(if_from_pc);

  // Reference model of the fetch stage.
  logic [15:0] m_pc     = 16'h0000;
  logic [15:0] m_instr  = 16'h0000;
  logic [15:0] m_pc2    = 16'h0000;
  logic        m_valid  = 1'b0;
  logic        m_halted = 1'b0;
  wire  [15:0] m_fetch  = mem(m_pc);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= 16'h0000; m_instr <= 16'h0000; m_pc2 <= 16'h0000;
      m_valid <= 1'b0; m_halted <= 1'b0;
    end else if (branch_taken) begin
      m_pc <= branch_target & 16'hFFFE;
      m_instr <= 16'h0000; m_pc2 <= 16'h0000; m_valid <= 1'b0;
      m_halted <= 1'b0;
    end else if (stall) begin
      m_pc <= m_pc;
    end else if (m_halted) begin
      m_instr <= 16'h0000; m_pc2 <= 16'h0000; m_valid <= 1'b0;
    end else begin
      m_instr <= m_fetch;
      m_pc2   <= m_pc + 16'd2;
      m_valid <= 1'b1;
      if (m_fetch[15:12] == 4'hF) m_halted <= 1'b1;
      else                        m_pc <= m_pc + 16'd2;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      check("model.pc",     if_from_pc,       m_pc);
      check("model.instr",  id_instruction,   m_instr);
      check("model.pc2",    id_pc_plus2,      m_pc2);
      check("model.valid",  16'(id_valid),    16'(m_valid));
      check("model.halted", 16'(halted),      16'(m_halted));
    end
  end

  // Advance exactly one rising edge; inputs change at negedge + 1.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_id(input string name, input logic [15:0] pc, input logic [15:0] ins,
                           input logic [15:0] pc2, input logic v, input logic h);
    check({name, ".pc"},     if_from_pc,     pc);
    check({name, ".instr"},  id_instruction, ins);
    check({name, ".pc2"},    id_pc_plus2,    pc2);
    check({name, ".valid"},  16'(id_valid),  16'(v));
    check({name, ".halted"}, 16'(halted),    16'(h));
  endtask

  initial begin
    #1;
    expect_id("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    cmp_en = 1'b1;

    // Free-running fetch
    tick(); expect_id("run1", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);
    tick(); expect_id("run2", 16'h0004, 16'h1002, 16'h0004, 1'b1, 1'b0);
    tick(); expect_id("run3", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);

    // Stall holds everything, release resumes at the held PC
    stall = 1'b1;
    tick(); expect_id("stall1", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);
    tick(); expect_id("stall2", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);
    stall = 1'b0;
    tick(); expect_id("resume", 16'h0008, 16'h1006, 16'h0008, 1'b1, 1'b0);

    // Branch wins over stall, odd target LSB dropped
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0041;
    tick(); expect_id("brstall", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0);
    stall = 1'b0;
    branch_target = 16'h0010;
    tick(); expect_id("br10", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0);
    branch_taken = 1'b0;

    // HALT capture, then bubbles, then branch out of HALT
    tick(); expect_id("halt", 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1);
    tick(); expect_id("haltbub", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick(); expect_id("haltbub2", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1);
    branch_taken = 1'b1; branch_target = 16'h0020;
    tick(); expect_id("unhalt", 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_id("run20", 16'h0022, 16'h1020, 16'h0022, 1'b1, 1'b0);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick(); expect_id("brtop", 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_id("wrap", 16'h0000, 16'h0FFE, 16'h0000, 1'b1, 1'b0);
    tick(); expect_id("wrap2", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    tick();
    #1 reset = 1'b0;
    #1 expect_id("asyncrst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick(); expect_id("postrst", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
